// File: rtl/blk_mem_arbiter.sv
// Block-memory arbiter: shares one wide main-memory block port between the
// I-cache and D-cache refill/writeback paths. One transfer at a time, round-robin
// on contention, pipeline FREEZE while anything is pending, and a per-transfer
// watchdog that aborts a transfer the memory never acknowledges.
module blk_mem_arbiter #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned BLK_W   = 256
) (
    input  logic             CLK,
    input  logic             RESET,

    // I-side requester
    input  logic             i_req,
    input  logic             i_we,
    input  logic [31:0]      i_addr,
    input  logic [BLK_W-1:0] i_wdata,
    output logic             i_done,
    output logic [BLK_W-1:0] i_rdata,

    // D-side requester
    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [BLK_W-1:0] d_wdata,
    output logic             d_done,
    output logic [BLK_W-1:0] d_rdata,

    // Main-memory block port
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [BLK_W-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [BLK_W-1:0] mem_rdata,

    output logic             FREEZE,
    output logic             timeout_err
);

    // Watchdog counter only needs to reach TIMEOUT-1
    localparam int unsigned WdCntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic SideI = 1'b0;
    localparam logic SideD = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

    state_e              r_state;
    logic                r_sel;        // side owning the current transfer
    logic                r_last;       // side granted most recently
    logic [WdCntW-1:0]   r_wd_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [BLK_W-1:0]    r_mem_wdata;
    logic                r_i_done;
    logic                r_d_done;
    logic [BLK_W-1:0]    r_i_rdata;
    logic [BLK_W-1:0]    r_d_rdata;
    logic                r_timeout_err;

    logic                w_req_any;
    logic                w_grant_d;
    logic                w_sel_we;
    logic [31:0]         w_sel_addr;
    logic [BLK_W-1:0]    w_sel_wdata;
    logic                w_wd_expired;

    // Arbitration: a lone requester wins; on a tie the side not granted last wins
    assign w_req_any   = i_req | d_req;
    assign w_grant_d   = d_req & (~i_req | (r_last == SideI));
    assign w_sel_we    = w_grant_d ? d_we    : i_we;
    assign w_sel_addr  = w_grant_d ? d_addr  : i_addr;
    assign w_sel_wdata = w_grant_d ? d_wdata : i_wdata;

    assign w_wd_expired = (r_wd_cnt == WdCntW'(TIMEOUT - 1));

    // Transfer sequencer; all outputs except FREEZE are registered here
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= StIdle;
            r_sel         <= SideI;
            r_last        <= SideI;
            r_wd_cnt      <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_i_done      <= 1'b0;
            r_d_done      <= 1'b0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            // done is a single-cycle pulse, raised only on entry to StResp
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (w_req_any) begin
                        r_sel       <= w_grant_d;
                        r_last      <= w_grant_d;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_req   <= 1'b1;
                        r_wd_cnt    <= '0;
                        r_state     <= StIssue;
                    end
                end

                StIssue: begin
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            if (r_sel == SideD) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                        r_mem_req <= 1'b0;
                        r_wd_cnt  <= '0;
                        r_i_done  <= (r_sel == SideI);
                        r_d_done  <= (r_sel == SideD);
                        r_state   <= StResp;
                    end else if (w_wd_expired) begin
                        // Abort: reads return zeros so the requester never sees stale data
                        r_timeout_err <= 1'b1;
                        if (!r_mem_we) begin
                            if (r_sel == SideD) begin
                                r_d_rdata <= '0;
                            end else begin
                                r_i_rdata <= '0;
                            end
                        end
                        r_mem_req <= 1'b0;
                        r_wd_cnt  <= '0;
                        r_i_done  <= (r_sel == SideI);
                        r_d_done  <= (r_sel == SideD);
                        r_state   <= StResp;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WdCntW'(1);
                    end
                end

                StResp: begin
                    // No arbitration here: the finished requester drops req next cycle
                    r_wd_cnt <= '0;
                    r_state  <= StIdle;
                end

                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

    // Stall the pipeline while any request is outstanding or a transfer is in flight
    assign FREEZE = i_req | d_req | (r_state != StIdle);

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign i_done      = r_i_done;
    assign d_done      = r_d_done;
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_blk_mem_arbiter.sv
// Directed bench for blk_mem_arbiter with a short watchdog (TIMEOUT=8).
module tb_blk_mem_arbiter;

    localparam int unsigned BW = 256;
    localparam int unsigned TO = 8;

    localparam logic [BW-1:0] PA5 = {32{8'hA5}};
    localparam logic [BW-1:0] P5A = {32{8'h5A}};
    localparam logic [BW-1:0] PFF = {32{8'hFF}};
    localparam logic [BW-1:0] PC3 = {32{8'hC3}};
    localparam logic [BW-1:0] PW  = {4{64'h0123456789ABCDEF}};

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          i_req = 1'b0, i_we = 1'b0;
    logic [31:0]   i_addr = '0;
    logic [BW-1:0] i_wdata = '0;
    logic          i_done;
    logic [BW-1:0] i_rdata;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [31:0]   d_addr = '0;
    logic [BW-1:0] d_wdata = '0;
    logic          d_done;
    logic [BW-1:0] d_rdata;
    logic          mem_req, mem_we;
    logic [31:0]   mem_addr;
    logic [BW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [BW-1:0] mem_rdata = '0;
    logic          FREEZE, timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    blk_mem_arbiter #(.TIMEOUT(TO), .BLK_W(BW)) dut (
        .CLK(CLK), .RESET(RESET),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .FREEZE(FREEZE), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic          ir;
        logic          iw;
        logic          dr;
        logic          ak;
        logic [BW-1:0] rd;
        logic          e_mreq;
        logic          e_idone;
        logic          e_ddone;
        logic          e_frz;
        logic [31:0]   e_addr;
        logic          e_we;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic dr, input logic ak,
                                input logic [BW-1:0] rd, input logic em, input logic eid,
                                input logic edd, input logic efz, input logic [31:0] ea);
        vec_t v;
        v.ir = ir; v.iw = 1'b0; v.dr = dr; v.ak = ak; v.rd = rd;
        v.e_mreq = em; v.e_idone = eid; v.e_ddone = edd; v.e_frz = efz;
        v.e_addr = ea; v.e_we = 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    vec_t tbl [8];

    initial begin
        logic       i_off, d_off, ack_nx;
        int         mcnt, nd;
        logic [3:0] order;

        // Asynchronous reset, checked before any clock edge
        #2 RESET = 1'b0;
        #1;
        chk("rst_mem_req",   256'(mem_req),     256'(0));
        chk("rst_mem_we",    256'(mem_we),      256'(0));
        chk("rst_mem_addr",  256'(mem_addr),    256'(0));
        chk("rst_mem_wdata", mem_wdata,         '0);
        chk("rst_i_done",    256'(i_done),      256'(0));
        chk("rst_d_done",    256'(d_done),      256'(0));
        chk("rst_i_rdata",   i_rdata,           '0);
        chk("rst_d_rdata",   d_rdata,           '0);
        chk("rst_tmo",       256'(timeout_err), 256'(0));
        chk("rst_freeze",    256'(FREEZE),      256'(0));
        @(posedge CLK);
        #1 RESET = 1'b1;

        // Contention: both sides request, each re-requests one cycle after its done
        i_addr = 32'h100; d_addr = 32'h200; mem_rdata = P5A;
        i_off = 1'b0; d_off = 1'b0; ack_nx = 1'b0; mcnt = 0; nd = 0; order = '0;
        for (int c = 0; c < 60 && nd < 4; c++) begin
            i_req = ~i_off; d_req = ~d_off; mem_ack = ack_nx;
            mid();
            chk("rr_no_overlap", 256'(i_done & d_done), 256'(0));
            if ((i_done || d_done) && nd < 4) begin
                order[nd] = d_done;
                nd++;
            end
            i_off = i_done; d_off = d_done;
            mcnt = mem_req ? mcnt + 1 : 0;
            ack_nx = (mcnt == 1);
            tick();
        end
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        chk("rr_ndone", 256'(nd), 256'(4));
        chk("rr_order_DIDI", 256'(order), 256'(4'b0101));
        chk("rr_i_rdata", i_rdata, P5A);
        chk("rr_d_rdata", d_rdata, P5A);
        mid();
        chk("rr_idle_freeze", 256'(FREEZE), 256'(0));
        tick();

        // Stray ack in IDLE, then an I read acked in cycle 3, then another stray ack
        tbl[0] = mk(1'b0, 1'b0, 1'b1, PFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[1] = mk(1'b1, 1'b0, 1'b0, '0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tbl[2] = mk(1'b1, 1'b0, 1'b0, '0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h400);
        tbl[3] = mk(1'b1, 1'b0, 1'b0, '0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h400);
        tbl[4] = mk(1'b1, 1'b0, 1'b1, PA5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400);
        tbl[5] = mk(1'b1, 1'b0, 1'b0, '0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        tbl[6] = mk(1'b0, 1'b0, 1'b0, '0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[7] = mk(1'b0, 1'b0, 1'b1, PFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        i_addr = 32'h0000_0400;
        for (int i = 0; i < 8; i++) begin
            i_req = tbl[i].ir; i_we = tbl[i].iw; d_req = tbl[i].dr;
            mem_ack = tbl[i].ak; mem_rdata = tbl[i].rd;
            mid();
            chk($sformatf("v%0d_mem_req", i), 256'(mem_req), 256'(tbl[i].e_mreq));
            chk($sformatf("v%0d_i_done", i),  256'(i_done),  256'(tbl[i].e_idone));
            chk($sformatf("v%0d_d_done", i),  256'(d_done),  256'(tbl[i].e_ddone));
            chk($sformatf("v%0d_freeze", i),  256'(FREEZE),  256'(tbl[i].e_frz));
            if (tbl[i].e_mreq) begin
                chk($sformatf("v%0d_mem_addr", i), 256'(mem_addr), 256'(tbl[i].e_addr));
                chk($sformatf("v%0d_mem_we", i),   256'(mem_we),   256'(tbl[i].e_we));
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("ird_i_rdata", i_rdata, PA5);
        chk("ird_d_rdata", d_rdata, P5A);

        // D write acked in cycle 1; d_rdata must keep its previous value
        d_addr = 32'h1000_0020; d_wdata = PW; d_we = 1'b1; d_req = 1'b1; mem_rdata = PFF;
        mid();
        chk("dwr_c0_mem_req", 256'(mem_req), 256'(0));
        tick();
        mem_ack = 1'b1;
        mid();
        chk("dwr_c1_mem_req", 256'(mem_req),  256'(1));
        chk("dwr_c1_mem_we",  256'(mem_we),   256'(1));
        chk("dwr_c1_addr",    256'(mem_addr), 256'(32'h1000_0020));
        chk("dwr_c1_wdata",   mem_wdata,      PW);
        tick();
        mem_ack = 1'b0;
        mid();
        chk("dwr_c2_d_done", 256'(d_done), 256'(1));
        chk("dwr_c2_i_done", 256'(i_done), 256'(0));
        chk("dwr_d_rdata",   d_rdata,      P5A);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        mid();
        chk("dwr_c3_d_done", 256'(d_done), 256'(0));
        tick();

        // D read never acknowledged: watchdog aborts after TO cycles
        d_addr = 32'h2000_0000; d_req = 1'b1;
        mid();
        tick();
        for (int c = 1; c <= int'(TO); c++) begin
            mid();
            chk($sformatf("tmo_c%0d_mem_req", c), 256'(mem_req),     256'(1));
            chk($sformatf("tmo_c%0d_err", c),     256'(timeout_err), 256'(0));
            tick();
        end
        mid();
        chk("tmo_err",     256'(timeout_err), 256'(1));
        chk("tmo_d_done",  256'(d_done),      256'(1));
        chk("tmo_mem_req", 256'(mem_req),     256'(0));
        chk("tmo_d_rdata", d_rdata,           '0);
        tick();
        d_req = 1'b0; mem_ack = 1'b1; mem_rdata = PFF;  // late ack after abort
        mid();
        chk("tmo_late_d_done", 256'(d_done), 256'(0));
        chk("tmo_late_freeze", 256'(FREEZE), 256'(0));
        tick();
        mem_ack = 1'b0;
        mid();
        chk("tmo_late_d_rdata", d_rdata, '0);
        tick();

        // Normal I read after the timeout; the error flag stays sticky
        i_addr = 32'h0000_0400; i_req = 1'b1;
        mid();
        tick();
        mem_ack = 1'b1; mem_rdata = PC3;
        mid();
        tick();
        mem_ack = 1'b0;
        mid();
        chk("post_i_done",  256'(i_done),      256'(1));
        chk("post_i_rdata", i_rdata,           PC3);
        chk("post_err",     256'(timeout_err), 256'(1));
        tick();
        i_req = 1'b0;
        mid();
        chk("post_err_hold", 256'(timeout_err), 256'(1));
        tick();

        // Reset during ISSUE of an I read
        i_req = 1'b1;
        mid();
        tick();
        mid();
        chk("rmid_mem_req_pre", 256'(mem_req), 256'(1));
        tick();
        RESET = 1'b0;
        #1;
        chk("rmid_mem_req", 256'(mem_req),     256'(0));
        chk("rmid_err",     256'(timeout_err), 256'(0));
        chk("rmid_i_rdata", i_rdata,           '0);
        i_req = 1'b0;
        #1;
        chk("rmid_idle", 256'(FREEZE), 256'(0));
        for (int c = 0; c < 3; c++) begin
            mid();
            chk($sformatf("rmid_no_done_%0d", c), 256'(i_done), 256'(0));
            tick();
        end
        i_addr = 32'h100; d_addr = 32'h200; i_req = 1'b1; d_req = 1'b1;
        RESET = 1'b1;
        mid();
        chk("rrel_c0_mem_req", 256'(mem_req), 256'(0));
        chk("rrel_c0_freeze",  256'(FREEZE),  256'(1));
        tick();
        mid();
        chk("rrel_c1_mem_req", 256'(mem_req),  256'(1));
        chk("rrel_d_first",    256'(mem_addr), 256'(32'h200));
        tick();
        mem_ack = 1'b1; mem_rdata = PA5;
        mid();
        tick();
        mem_ack = 1'b0;
        mid();
        chk("rrel_d_done", 256'(d_done), 256'(1));
        chk("rrel_i_done", 256'(i_done), 256'(0));
        tick();
        d_req = 1'b0; i_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/blk_mem_arbiter.md
# blk_mem_arbiter

Arbitrates the single 256-bit main-memory block port between the instruction-cache path (iBlkRead/iBlkWrite) and the data-cache path (dBlkRead/dBlkWrite) of the pipelined MIPS. It sequences one block transfer at a time through a three-state FSM and alternates grants round-robin when both sides contend. It drives FREEZE to the pipeline stages while any block transfer is pending. A watchdog bounds each memory transaction.

## Interface
- TIMEOUT, 64: max cycles in ISSUE without mem_ack before abort (≥2)
- BLK_W, 256: block width in bits
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- i_req  in  1  I-side block request; held until i_done
- i_we  in  1  I-side write (1) / read (0); stable while i_req
- i_addr  in  32  I-side block address; stable while i_req
- i_wdata  in  BLK_W  I-side write block
- i_done  out  1  one-cycle completion pulse to I-side
- i_rdata  out  BLK_W  I-side read block, registered
- d_req, d_we, d_addr, d_wdata, d_done, d_rdata: D-side equivalents, same widths and rules
- mem_req  out  1  request to memory, registered
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory block address
- mem_wdata  out  BLK_W  memory write block
- mem_ack  in  1  memory completion; mem_rdata valid same cycle
- mem_rdata  in  BLK_W  memory read block
- FREEZE  out  1  pipeline stall
- timeout_err  out  1  sticky watchdog error

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE:
  - No req: stay.
  - Exactly one req: grant it.
  - Both reqs: grant the side not granted last. last_grant resets to I, so D wins the first tie.
  - On grant: latch sel, we, addr, wdata into mem_* registers, set mem_req=1, update last_grant, go to ISSUE.
- ISSUE: mem_req held high, mem_* stable.
  - mem_ack=1: on reads, capture mem_rdata into the selected requester's rdata register. Clear mem_req, go to RESP.
  - Otherwise increment wd_cnt. When wd_cnt == TIMEOUT-1 with no ack: set timeout_err, load 0 into the selected rdata (reads only), clear mem_req, go to RESP.
- RESP: pulse the selected done for one cycle, clear wd_cnt, go to IDLE.
- Requester rule: req must be low in the cycle after its done pulse. The arbiter never re-arbitrates in RESP.
- Writes leave the requester's rdata register unchanged.
- mem_ack in IDLE or RESP is ignored. A late ack after timeout has no effect.
- Non-selected requester's done stays 0. Its req stays pending and is served next.
- FREEZE = i_req | d_req | (state != IDLE). Combinational.
- timeout_err stays 1 until RESET. Operation continues normally after it is set.
- wd_cnt width is clog2(TIMEOUT). It never wraps because it is cleared on leaving ISSUE.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_done=d_done=0, i_rdata=d_rdata=0, timeout_err=0, wd_cnt=0, last_grant=I. FREEZE follows its equation (0 with no reqs).
- RESET asserted mid-transaction: immediate (asynchronous) return to the reset values. The in-flight transfer is abandoned and no done pulses.
- Cycle numbering: req is high in cycle 0, sampled at the edge ending cycle 0.
  - mem_req is high from cycle 1.
  - If ack arrives in cycle k≥1, done is high in cycle k+1 and rdata is valid from cycle k+1.
  - Minimum req→done latency is 2 cycles (ack in cycle 1).
  - The next grant is made at the earliest in the IDLE cycle k+2, with mem_req high in k+3.
- Timeout: with no ack, mem_req is high in cycles 1..TIMEOUT. timeout_err and done are high in cycle TIMEOUT+1.
- Back-to-back contention: transfers alternate I/D. No side waits more than one other transfer.

## Test plan
- I read, addr 0x0000_0400, ack in cycle 3 with mem_rdata=0xA5…A5 → mem_req high cycles 1–3, mem_addr=0x400, mem_we=0; i_done high in cycle 4 only; i_rdata=0xA5…A5; d_done stays 0; FREEZE high cycles 0–4.
- i_req and d_req rise together, each re-requested after done, ack 1 cycle after each mem_req → grant order D, I, D, I; no done overlap.
- D write, addr 0x1000_0020, wdata=0x0123…, ack in cycle 1 → mem_we=1 and mem_wdata match in cycle 1; d_done in cycle 2; d_rdata unchanged from its prior value.
- TIMEOUT=8, D read, never ack → mem_req high cycles 1–8; timeout_err=1 and d_done=1 in cycle 9; d_rdata=0. A following I read with ack completes normally and timeout_err stays 1.
- RESET low during ISSUE of an I read → mem_req=0 and state=IDLE immediately. No i_done is pulsed. After RESET releases with both reqs high, D is granted first.
- Stray mem_ack in IDLE → no state change, no done, rdata unchanged.
